// File: rtl/common_bypass_arbiter.sv
// Zero-latency round-robin arbiter feeding one bypass-buffer input from NUM_REQ requesters.
// Grants stay locked through backpressure and for up to MAX_BURST beats before rotating.
module common_bypass_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_i_data,
  input  logic [NUM_REQ-1:0]            req_i_valid,
  output logic [NUM_REQ-1:0]            req_o_ready,
  output logic [DATA_WIDTH-1:0]         next_o_data,
  output logic                          next_o_valid,
  output logic [ID_WIDTH-1:0]           next_o_id,
  input  logic                          next_i_ready
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] IdLast = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {StIdle, StLocked} mode_e;

  mode_e               mode_q, mode_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                locked_hit;
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] cand;
  logic [CntW-1:0]     eff_cnt;
  logic                fire;
  logic                stall;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
    return (v == IdLast) ? '0 : v + 1'b1;
  endfunction

  // Grant selection: a live lock wins, otherwise search from ptr with wrap.
  always_comb begin
    locked_hit  = (mode_q == StLocked) && req_i_valid[owner_q];
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    if (locked_hit) begin
      grant_found = 1'b1;
      grant       = owner_q;
    end else begin
      // Descending scan so the smallest offset from ptr is the last one kept.
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
        cand = ID_WIDTH'((int'(ptr_q) + k) % int'(NUM_REQ));
        if (req_i_valid[cand]) begin
          grant_found = 1'b1;
          grant       = cand;
        end
      end
    end
    // A burst only continues when the lock is still being honoured.
    eff_cnt = locked_hit ? cnt_q : '0;
    fire    = grant_found & next_i_ready;
    stall   = grant_found & ~next_i_ready;
  end

  always_comb begin
    next_o_valid = resetn & grant_found;
    next_o_id    = (resetn && grant_found) ? grant : '0;
    next_o_data  = '0;
    req_o_ready  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (resetn && grant_found && (grant == ID_WIDTH'(i))) begin
        next_o_data    = req_i_data[i*int'(DATA_WIDTH) +: DATA_WIDTH];
        req_o_ready[i] = fire;
      end
    end
  end

  always_comb begin
    mode_d  = mode_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!grant_found) begin
      mode_d = StIdle;
      cnt_d  = '0;
      // Only reachable from a lock when the owner has dropped.
      if (mode_q == StLocked) begin
        ptr_d = wrap_inc(owner_q);
      end
    end else if (stall) begin
      mode_d  = StLocked;
      owner_d = grant;
      cnt_d   = eff_cnt;
    end else if (eff_cnt == CntLast) begin
      mode_d = StIdle;
      cnt_d  = '0;
      ptr_d  = wrap_inc(grant);
    end else begin
      mode_d  = StLocked;
      owner_d = grant;
      cnt_d   = eff_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q  <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_common_bypass_arbiter.sv
// Randomized plus directed bench: three arbiter configurations run in lockstep against a
// burst/round-robin reference model.
module tb_common_bypass_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Instance A: 4 requesters, burst 4. B: 4 requesters, burst 1. C: 3 requesters, burst 1.
  logic [4*DW-1:0] a_data;
  logic [3:0]      a_valid, a_rdy;
  logic [DW-1:0]   a_odata;
  logic            a_ovalid, a_ready;
  logic [1:0]      a_oid;

  logic [4*DW-1:0] b_data;
  logic [3:0]      b_valid, b_rdy;
  logic [DW-1:0]   b_odata;
  logic            b_ovalid, b_ready;
  logic [1:0]      b_oid;

  logic [3*DW-1:0] c_data;
  logic [2:0]      c_valid, c_rdy;
  logic [DW-1:0]   c_odata;
  logic            c_ovalid, c_ready;
  logic [1:0]      c_oid;

  common_bypass_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .ID_WIDTH(2), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .resetn(resetn), .req_i_data(a_data), .req_i_valid(a_valid),
    .req_o_ready(a_rdy), .next_o_data(a_odata), .next_o_valid(a_ovalid),
    .next_o_id(a_oid), .next_i_ready(a_ready)
  );

  common_bypass_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .ID_WIDTH(2), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .req_i_data(b_data), .req_i_valid(b_valid),
    .req_o_ready(b_rdy), .next_o_data(b_odata), .next_o_valid(b_ovalid),
    .next_o_id(b_oid), .next_i_ready(b_ready)
  );

  common_bypass_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .ID_WIDTH(2), .MAX_BURST(1)) u_dut_c (
    .clk(clk), .resetn(resetn), .req_i_data(c_data), .req_i_valid(c_valid),
    .req_o_ready(c_rdy), .next_o_data(c_odata), .next_o_valid(c_ovalid),
    .next_o_id(c_oid), .next_i_ready(c_ready)
  );

  int nreq[3];
  int mbst[3];

  bit          s_valid[3][4];
  logic [31:0] s_data[3][4];
  bit          s_ready[3];

  // Model: pending = beat offered but not yet taken, run = beats taken in current burst.
  int m_ptr[3];
  int m_pend[3];
  int m_rown[3];
  int m_rlen[3];

  bit          obs_valid[3];
  int          obs_id[3];
  logic [31:0] obs_data[3];
  logic [3:0]  obs_rdy[3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lock_owner(input int k);
    if (m_pend[k] >= 0) return m_pend[k];
    if (m_rlen[k] > 0) return m_rown[k];
    return -1;
  endfunction

  function automatic int model_grant(input int k, output int eff);
    int c;
    c   = lock_owner(k);
    eff = 0;
    if (c >= 0 && s_valid[k][c]) begin
      eff = m_rlen[k];
      return c;
    end
    for (int j = 0; j < nreq[k]; j++) begin
      int idx;
      idx = (m_ptr[k] + j) % nreq[k];
      if (s_valid[k][idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_update(input int k);
    int eff, g, c;
    g = model_grant(k, eff);
    c = lock_owner(k);
    if (!resetn) begin
      m_ptr[k] = 0; m_pend[k] = -1; m_rown[k] = 0; m_rlen[k] = 0;
    end else if (g < 0) begin
      if (c >= 0) m_ptr[k] = (c + 1) % nreq[k];
      m_pend[k] = -1;
      m_rlen[k] = 0;
    end else if (!s_ready[k]) begin
      m_pend[k] = g; m_rown[k] = g; m_rlen[k] = eff;
    end else begin
      m_pend[k] = -1;
      if (eff == mbst[k] - 1) begin
        m_rlen[k] = 0;
        m_ptr[k]  = (g + 1) % nreq[k];
      end else begin
        m_rown[k] = g;
        m_rlen[k] = eff + 1;
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      a_valid[i] = s_valid[0][i]; a_data[i*DW +: DW] = s_data[0][i];
      b_valid[i] = s_valid[1][i]; b_data[i*DW +: DW] = s_data[1][i];
    end
    for (int i = 0; i < 3; i++) begin
      c_valid[i] = s_valid[2][i]; c_data[i*DW +: DW] = s_data[2][i];
    end
    a_ready = s_ready[0];
    b_ready = s_ready[1];
    c_ready = s_ready[2];
  endtask

  task automatic observe(input int k);
    case (k)
      0: begin
        obs_valid[k] = a_ovalid; obs_id[k] = int'(a_oid);
        obs_data[k] = a_odata; obs_rdy[k] = a_rdy;
      end
      1: begin
        obs_valid[k] = b_ovalid; obs_id[k] = int'(b_oid);
        obs_data[k] = b_odata; obs_rdy[k] = b_rdy;
      end
      default: begin
        obs_valid[k] = c_ovalid; obs_id[k] = int'(c_oid);
        obs_data[k] = c_odata; obs_rdy[k] = {1'b0, c_rdy};
      end
    endcase
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int eff, g;
      bit e_valid;
      int e_id;
      logic [31:0] e_data;
      logic [3:0]  e_rdy;
      observe(k);
      g = model_grant(k, eff);
      e_valid = resetn && (g >= 0);
      e_id    = e_valid ? g : 0;
      e_data  = e_valid ? s_data[k][g] : 32'h0;
      e_rdy   = (e_valid && s_ready[k]) ? 4'(1 << g) : 4'h0;
      check_eq($sformatf("model_valid[%0d]", k), 64'(obs_valid[k]), 64'(e_valid));
      check_eq($sformatf("model_id[%0d]", k), 64'(obs_id[k]), 64'(e_id));
      check_eq($sformatf("model_data[%0d]", k), 64'(obs_data[k]), 64'(e_data));
      check_eq($sformatf("model_ready[%0d]", k), 64'(obs_rdy[k]), 64'(e_rdy));
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step();
    apply();
    #1;
    check_all();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_all(input logic [3:0] v, input bit rdy);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) s_valid[k][i] = (i < nreq[k]) ? v[i] : 1'b0;
      s_ready[k] = rdy;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_all(4'b0000, 1'b1);
    step();
    resetn = 1'b1;
  endtask

  int exp_burst[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int exp_bp[5]    = '{0, 0, 0, 0, 1};

  initial begin
    nreq = '{4, 4, 3};
    mbst = '{4, 1, 1};
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0; m_pend[k] = -1; m_rown[k] = 0; m_rlen[k] = 0;
      for (int i = 0; i < 4; i++) s_data[k][i] = $urandom;
    end
    resetn = 1'b0;
    set_all(4'b1111, 1'b1);
    @(negedge clk);

    // Reset with every requester valid: nothing may be offered.
    for (int j = 0; j < 2; j++) begin
      step();
      check_eq("rst_valid", 64'(obs_valid[0]), 64'd0);
      check_eq("rst_ready", 64'(obs_rdy[0]), 64'd0);
      check_eq("rst_id", 64'(obs_id[0]), 64'd0);
    end
    resetn = 1'b1;
    step();
    check_eq("post_rst_id", 64'(obs_id[0]), 64'd0);
    check_eq("post_rst_valid", 64'(obs_valid[0]), 64'd1);

    // Burst of 4 then rotation on A.
    do_reset();
    set_all(4'b0011, 1'b1);
    for (int j = 0; j < 9; j++) begin
      step();
      check_eq($sformatf("burst_id[%0d]", j), 64'(obs_id[0]), 64'(exp_burst[j]));
    end

    // Strict per-beat round robin on B.
    do_reset();
    set_all(4'b1111, 1'b1);
    for (int j = 0; j < 8; j++) begin
      step();
      check_eq($sformatf("rr_id[%0d]", j), 64'(obs_id[1]), 64'(j % 4));
      check_eq($sformatf("rr_ready[%0d]", j), 64'(obs_rdy[1]), 64'(1 << (j % 4)));
    end

    // Non-power-of-two wrap on C.
    do_reset();
    set_all(4'b0101, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step();
      check_eq($sformatf("wrap_id[%0d]", j), 64'(obs_id[2]), 64'((j % 2) * 2));
    end

    // Backpressure on A: offer must hold, stalls do not consume burst budget.
    do_reset();
    set_all(4'b0011, 1'b0);
    s_data[0][0] = 32'hDEADBEEF;
    for (int j = 0; j < 3; j++) begin
      step();
      check_eq($sformatf("bp_id[%0d]", j), 64'(obs_id[0]), 64'd0);
      check_eq($sformatf("bp_data[%0d]", j), 64'(obs_data[0]), 64'hDEADBEEF);
      check_eq($sformatf("bp_ready[%0d]", j), 64'(obs_rdy[0]), 64'd0);
    end
    set_all(4'b0011, 1'b1);
    for (int j = 0; j < 5; j++) begin
      step();
      check_eq($sformatf("bp_rel_id[%0d]", j), 64'(obs_id[0]), 64'(exp_bp[j]));
      if (j == 0) check_eq("bp_accept", 64'(obs_rdy[0]), 64'b0001);
    end

    // Owner drop on A: lock on 2, then 2 falls while 3 is valid.
    do_reset();
    set_all(4'b0100, 1'b1);
    step();
    check_eq("drop_lock_id", 64'(obs_id[0]), 64'd2);
    set_all(4'b1000, 1'b1);
    step();
    check_eq("drop_new_id", 64'(obs_id[0]), 64'd3);
    check_eq("drop_ready", 64'(obs_rdy[0]), 64'b1000);

    // Random traffic with occasional reset and protocol violations.
    for (int j = 0; j < 3000; j++) begin
      resetn = ($urandom_range(0, 149) != 0);
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < nreq[k]; i++) begin
          if ($urandom_range(0, 99) < 25) s_valid[k][i] = ~s_valid[k][i];
          s_data[k][i] = $urandom;
        end
        s_ready[k] = ($urandom_range(0, 99) < 70);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
